// File: rtl/fruit_spawn_controller.sv
// Places collectible fruits at random spots, verifies each spot for one frame, retries bad
// spots and hides eaten fruits for a respawn cooldown. All outputs are registered.
module fruit_spawn_controller #(
  parameter int NUM_FRUITS     = 4,
  parameter int RESPAWN_FRAMES = 90,
  parameter int MAX_RETRIES    = 7,
  parameter int X_MAX          = 575,
  parameter int Y_MAX          = 415
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     startOfFrame,
  input  logic [10:0]              randomX,
  input  logic [10:0]              randomY,
  input  logic [NUM_FRUITS-1:0]    illegalPlacement,
  input  logic [NUM_FRUITS-1:0]    monkeyCollision,
  output logic [NUM_FRUITS*11-1:0] fruitX,
  output logic [NUM_FRUITS*11-1:0] fruitY,
  output logic [NUM_FRUITS-1:0]    drawFruit,
  output logic                     eatenPulse,
  output logic [7:0]               eatenCount
);

  typedef enum logic [1:0] {
    S_EMPTY    = 2'd0,
    S_VERIFY   = 2'd1,
    S_ACTIVE   = 2'd2,
    S_COOLDOWN = 2'd3
  } slot_state_t;

  localparam logic [10:0] X_LIM     = 11'(X_MAX);
  localparam logic [10:0] Y_LIM     = 11'(Y_MAX);
  localparam logic [7:0]  CD_INIT   = 8'(RESPAWN_FRAMES);
  localparam logic [3:0]  RETRY_LIM = 4'(MAX_RETRIES);

  slot_state_t slot_state_q [NUM_FRUITS];
  slot_state_t slot_state_d [NUM_FRUITS];
  logic [3:0]  retry_q      [NUM_FRUITS];
  logic [3:0]  retry_d      [NUM_FRUITS];
  logic [7:0]  cooldown_q   [NUM_FRUITS];
  logic [7:0]  cooldown_d   [NUM_FRUITS];

  logic [NUM_FRUITS-1:0]    ill_flag_q, ill_flag_d;
  logic [NUM_FRUITS-1:0]    pending_q, pending_d;
  logic [NUM_FRUITS*11-1:0] fruit_x_q, fruit_x_d;
  logic [NUM_FRUITS*11-1:0] fruit_y_q, fruit_y_d;
  logic [NUM_FRUITS-1:0]    draw_q, draw_d;
  logic                     eaten_pulse_q, eaten_pulse_d;
  logic [7:0]               eaten_count_q, eaten_count_d;

  logic [10:0]           place_x, place_y;
  logic [NUM_FRUITS-1:0] verify_mask, active_mask, empty_mask;
  logic [NUM_FRUITS-1:0] ill_seen, pick_mask, hit_mask, eat_req, eat_sel;
  logic                  engine_busy;

  function automatic logic [NUM_FRUITS-1:0] lowest_set(input logic [NUM_FRUITS-1:0] v);
    logic found;
    lowest_set = '0;
    found      = 1'b0;
    for (int i = 0; i < NUM_FRUITS; i++) begin
      if (v[i] && !found) begin
        lowest_set[i] = 1'b1;
        found         = 1'b1;
      end
    end
  endfunction

  always_comb begin
    for (int k = 0; k < NUM_FRUITS; k++) begin
      verify_mask[k] = (slot_state_q[k] == S_VERIFY);
      active_mask[k] = (slot_state_q[k] == S_ACTIVE);
      empty_mask[k]  = (slot_state_q[k] == S_EMPTY);
    end
  end

  // A pulse landing on the startOfFrame cycle still belongs to the frame that is ending.
  assign ill_seen    = ill_flag_q | (illegalPlacement & verify_mask);
  assign place_x     = (randomX > X_LIM) ? X_LIM : randomX;
  assign place_y     = (randomY > Y_LIM) ? Y_LIM : randomY;
  assign engine_busy = |verify_mask;
  assign pick_mask   = (startOfFrame && !engine_busy) ? lowest_set(empty_mask) : '0;
  assign hit_mask    = monkeyCollision & active_mask;
  assign eat_req     = pending_q | hit_mask;
  assign eat_sel     = lowest_set(eat_req);

  always_comb begin
    fruit_x_d  = fruit_x_q;
    fruit_y_d  = fruit_y_q;
    ill_flag_d = startOfFrame ? '0 : ill_seen;
    draw_d     = '0;
    for (int k = 0; k < NUM_FRUITS; k++) begin
      slot_state_d[k] = slot_state_q[k];
      retry_d[k]      = retry_q[k];
      cooldown_d[k]   = cooldown_q[k];
      unique case (slot_state_q[k])
        S_EMPTY: begin
          if (pick_mask[k]) begin
            slot_state_d[k]       = S_VERIFY;
            retry_d[k]            = 4'd0;
            fruit_x_d[11*k +: 11] = place_x;
            fruit_y_d[11*k +: 11] = place_y;
          end
        end
        S_VERIFY: begin
          if (startOfFrame) begin
            if (!ill_seen[k]) begin
              slot_state_d[k] = S_ACTIVE;
            end else if (retry_q[k] < RETRY_LIM) begin
              retry_d[k]            = retry_q[k] + 4'd1;
              fruit_x_d[11*k +: 11] = place_x;
              fruit_y_d[11*k +: 11] = place_y;
            end else begin
              slot_state_d[k] = S_COOLDOWN;
              cooldown_d[k]   = CD_INIT;
            end
          end
        end
        S_ACTIVE: begin
          if (hit_mask[k]) begin
            slot_state_d[k] = S_COOLDOWN;
            cooldown_d[k]   = CD_INIT;
          end
        end
        S_COOLDOWN: begin
          if (startOfFrame) begin
            if (cooldown_q[k] <= 8'd1) begin
              cooldown_d[k]   = 8'd0;
              slot_state_d[k] = S_EMPTY;
            end else begin
              cooldown_d[k] = cooldown_q[k] - 8'd1;
            end
          end
        end
        default: ;
      endcase
      draw_d[k] = (slot_state_d[k] == S_VERIFY) || (slot_state_d[k] == S_ACTIVE);
    end
  end

  // Simultaneous eats drain one per cycle, lowest slot first, so the score sees every fruit.
  always_comb begin
    eaten_pulse_d = |eat_req;
    pending_d     = eat_req & ~eat_sel;
    eaten_count_d = eaten_count_q;
    if (|eat_req) begin
      eaten_count_d = eaten_count_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int k = 0; k < NUM_FRUITS; k++) begin
        slot_state_q[k] <= S_EMPTY;
        retry_q[k]      <= 4'd0;
        cooldown_q[k]   <= 8'd0;
      end
      ill_flag_q    <= '0;
      pending_q     <= '0;
      fruit_x_q     <= '0;
      fruit_y_q     <= '0;
      draw_q        <= '0;
      eaten_pulse_q <= 1'b0;
      eaten_count_q <= 8'd0;
    end else begin
      for (int k = 0; k < NUM_FRUITS; k++) begin
        slot_state_q[k] <= slot_state_d[k];
        retry_q[k]      <= retry_d[k];
        cooldown_q[k]   <= cooldown_d[k];
      end
      ill_flag_q    <= ill_flag_d;
      pending_q     <= pending_d;
      fruit_x_q     <= fruit_x_d;
      fruit_y_q     <= fruit_y_d;
      draw_q        <= draw_d;
      eaten_pulse_q <= eaten_pulse_d;
      eaten_count_q <= eaten_count_d;
    end
  end

  assign fruitX     = fruit_x_q;
  assign fruitY     = fruit_y_q;
  assign drawFruit  = draw_q;
  assign eatenPulse = eaten_pulse_q;
  assign eatenCount = eaten_count_q;

endmodule

// File: tb/tb_fruit_spawn_controller.sv
// Directed scenarios for fruit_spawn_controller; expectations queued at stimulus time and
// compared against the DUT outputs at each sample point.
`timescale 1ns/1ps
module tb_fruit_spawn_controller;
  localparam int NF      = 4;
  localparam int K_DRAW  = 0;
  localparam int K_PULSE = 1;
  localparam int K_COUNT = 2;
  localparam int K_X     = 16;
  localparam int K_Y     = 32;

  logic              clk = 1'b0;
  logic              resetN;
  logic              startOfFrame;
  logic [10:0]       randomX, randomY;
  logic [NF-1:0]     illegalPlacement, monkeyCollision;
  logic [NF*11-1:0]  fruitX, fruitY;
  logic [NF-1:0]     drawFruit;
  logic              eatenPulse;
  logic [7:0]        eatenCount;

  int    n_checks = 0;
  int    n_pass   = 0;
  string phase    = "init";

  typedef struct {
    int          kind;
    logic [31:0] val;
  } exp_t;
  exp_t sb_q[$];

  fruit_spawn_controller #(
    .NUM_FRUITS(NF), .RESPAWN_FRAMES(90), .MAX_RETRIES(7), .X_MAX(575), .Y_MAX(415)
  ) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame),
    .randomX(randomX), .randomY(randomY),
    .illegalPlacement(illegalPlacement), .monkeyCollision(monkeyCollision),
    .fruitX(fruitX), .fruitY(fruitY), .drawFruit(drawFruit),
    .eatenPulse(eatenPulse), .eatenCount(eatenCount)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] observe(input int kind);
    if (kind >= K_Y) return 32'(fruitY[11*(kind-K_Y) +: 11]);
    if (kind >= K_X) return 32'(fruitX[11*(kind-K_X) +: 11]);
    if (kind == K_DRAW) return 32'(drawFruit);
    if (kind == K_PULSE) return 32'(eatenPulse);
    return 32'(eatenCount);
  endfunction

  function automatic string kind_name(input int kind);
    if (kind >= K_Y) return $sformatf("fruitY[%0d]", kind - K_Y);
    if (kind >= K_X) return $sformatf("fruitX[%0d]", kind - K_X);
    if (kind == K_DRAW) return "drawFruit";
    if (kind == K_PULSE) return "eatenPulse";
    return "eatenCount";
  endfunction

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
  endtask

  task automatic expect_out(input int kind, input int val);
    exp_t e;
    e.kind = kind;
    e.val  = 32'(val);
    sb_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk_val($sformatf("%s/%s", phase, kind_name(e.kind)), observe(e.kind), e.val);
    end
  endtask

  task automatic frame(input logic [NF-1:0] ill_at_sof);
    repeat (2) @(negedge clk);
    startOfFrame     = 1'b1;
    illegalPlacement = ill_at_sof;
    @(negedge clk);
    startOfFrame     = 1'b0;
    illegalPlacement = '0;
  endtask

  task automatic pulse_ill(input logic [NF-1:0] mask);
    @(negedge clk);
    illegalPlacement = mask;
    @(negedge clk);
    illegalPlacement = '0;
  endtask

  task automatic pulse_monkey(input logic [NF-1:0] mask);
    @(negedge clk);
    monkeyCollision = mask;
    @(negedge clk);
    monkeyCollision = '0;
  endtask

  initial begin
    #100us;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    resetN = 1'b0; startOfFrame = 1'b0;
    randomX = 11'd100; randomY = 11'd50;
    illegalPlacement = '0; monkeyCollision = '0;
    repeat (3) @(negedge clk);

    phase = "reset";
    expect_out(K_DRAW, 0); expect_out(K_PULSE, 0); expect_out(K_COUNT, 0);
    expect_out(K_X+0, 0); expect_out(K_Y+0, 0); expect_out(K_X+3, 0);
    sample();
    resetN = 1'b1;

    phase = "startup";
    frame('0);
    expect_out(K_DRAW, 'b0001); expect_out(K_X+0, 100); expect_out(K_Y+0, 50); sample();
    pulse_monkey(4'b0001);
    expect_out(K_PULSE, 0); expect_out(K_COUNT, 0); expect_out(K_DRAW, 'b0001); sample();
    frame('0);
    expect_out(K_DRAW, 'b0001); sample();
    randomX = 11'd2000; randomY = 11'd1000;
    frame('0);
    expect_out(K_DRAW, 'b0011); expect_out(K_X+1, 575); expect_out(K_Y+1, 415);
    expect_out(K_X+0, 100); sample();
    randomX = 11'd200; randomY = 11'd120;
    frame('0);
    expect_out(K_DRAW, 'b0011); sample();
    frame('0);
    expect_out(K_DRAW, 'b0111); expect_out(K_X+2, 200); expect_out(K_Y+2, 120); sample();
    frame('0);
    randomX = 11'd576; randomY = 11'd414;
    frame('0);
    expect_out(K_DRAW, 'b1111); expect_out(K_X+3, 575); expect_out(K_Y+3, 414); sample();
    frame('0);
    expect_out(K_DRAW, 'b1111); sample();

    phase = "eat1";
    pulse_monkey(4'b0100);
    expect_out(K_DRAW, 'b1011); expect_out(K_PULSE, 1); expect_out(K_COUNT, 1); sample();
    @(negedge clk);
    expect_out(K_PULSE, 0); expect_out(K_COUNT, 1); sample();
    randomX = 11'd300; randomY = 11'd200;
    repeat (90) frame('0);
    expect_out(K_DRAW, 'b1011); expect_out(K_X+2, 200); sample();
    frame('0);
    expect_out(K_DRAW, 'b1111); expect_out(K_X+2, 300); expect_out(K_Y+2, 200); sample();
    frame('0);

    phase = "multi";
    pulse_monkey(4'b1011);
    expect_out(K_DRAW, 'b0100); expect_out(K_PULSE, 1); expect_out(K_COUNT, 2); sample();
    @(negedge clk);
    expect_out(K_PULSE, 1); expect_out(K_COUNT, 3); sample();
    @(negedge clk);
    expect_out(K_PULSE, 1); expect_out(K_COUNT, 4); sample();
    @(negedge clk);
    expect_out(K_PULSE, 0); expect_out(K_COUNT, 4); sample();

    phase = "rst_cooldown";
    frame('0);
    #2 resetN = 1'b0;
    #1;
    expect_out(K_DRAW, 0); expect_out(K_PULSE, 0); expect_out(K_COUNT, 0);
    expect_out(K_X+0, 0); expect_out(K_Y+0, 0); expect_out(K_X+2, 0); sample();
    @(negedge clk);
    resetN = 1'b1;

    phase = "retry";
    randomX = 11'd100; randomY = 11'd50;
    frame('0);
    expect_out(K_DRAW, 'b0001); expect_out(K_X+0, 100); sample();
    for (int i = 1; i <= 7; i++) begin
      randomX = 11'(10 * i); randomY = 11'(20 + i);
      if (i == 4) begin
        frame(4'b0001);
      end else begin
        pulse_ill(4'b0001);
        frame('0);
      end
      expect_out(K_DRAW, 'b0001); expect_out(K_X+0, 10 * i); expect_out(K_Y+0, 20 + i);
      sample();
    end
    randomX = 11'd400; randomY = 11'd300;
    pulse_ill(4'b0001);
    frame('0);
    expect_out(K_DRAW, 'b0000); expect_out(K_X+0, 70); expect_out(K_Y+0, 27); sample();
    frame(4'b0010);
    expect_out(K_DRAW, 'b0010); expect_out(K_X+1, 400); expect_out(K_Y+1, 300); sample();
    randomX = 11'd500; randomY = 11'd333;
    frame('0);
    expect_out(K_DRAW, 'b0010); expect_out(K_X+1, 400); expect_out(K_Y+1, 300); sample();
    frame('0);
    expect_out(K_DRAW, 'b0110); expect_out(K_X+2, 500); expect_out(K_Y+2, 333); sample();

    phase = "rst_verify";
    #2 resetN = 1'b0;
    #1;
    expect_out(K_DRAW, 0); expect_out(K_X+1, 0); expect_out(K_X+2, 0); sample();
    @(negedge clk);
    resetN = 1'b1;

    phase = "restart";
    randomX = 11'd123; randomY = 11'd45;
    frame('0);
    expect_out(K_DRAW, 'b0001); expect_out(K_X+0, 123); expect_out(K_Y+0, 45);
    expect_out(K_COUNT, 0); sample();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
